// File: rtl/fp_operand_stager.sv
// fp_operand_stager
//   Pairs consecutive packed IEEE-754 single-precision words from a
//   valid/ready stream into operands A and B for a combinational adder.
//   Each pair is unpacked into sign/exponent/fraction fields.
//   Denormals are flushed to zero.
//   NaN/Inf/zero cases are resolved here into a bypass result.
//   The staged pair is held bit-stable until downstream accepts it.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous abort of partial/staged pair
//   in_valid/in_ready   input handshake, in_data packed word
//   out_valid/out_ready output handshake for the staged pair
//   sign*/exp*/frac*    unpacked operand fields (A=1, B=2)
//   special             adder result must be replaced by special_result
//   special_result      packed bypass result
//   pair_cnt            count of pairs transferred downstream (wraps)
module fp_operand_stager #(
  parameter int unsigned CNT_W = 16,
  parameter logic [31:0] QNAN  = 32'h7FC0_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign1,
  output logic             sign2,
  output logic [7:0]       exp1,
  output logic [7:0]       exp2,
  output logic [22:0]      frac1,
  output logic [22:0]      frac2,
  output logic             special,
  output logic [31:0]      special_result,
  output logic [CNT_W-1:0] pair_cnt
);

  typedef enum logic [1:0] {WAIT_A, WAIT_B, FULL} state_t;

  state_t            state_q, state_d;
  logic [31:0]       a_q, a_d;
  logic              sign1_q, sign1_d, sign2_q, sign2_d;
  logic [7:0]        exp1_q, exp1_d, exp2_q, exp2_d;
  logic [22:0]       frac1_q, frac1_d, frac2_q, frac2_d;
  logic              special_q, special_d;
  logic [31:0]       sres_q, sres_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Classification of the pair being formed: A from a_q, B from in_data.
  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        cls_special;
  logic [31:0] cls_result;

  always_comb begin
    sa     = a_q[31];
    ea     = a_q[30:23];
    fa     = a_q[22:0];
    sb     = in_data[31];
    eb     = in_data[30:23];
    fb     = in_data[22:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (fa == '0);
    b_inf  = (eb == '1) && (fb == '0);
    a_nan  = (ea == '1) && (fa != '0);
    b_nan  = (eb == '1) && (fb != '0);

    cls_special = 1'b1;
    cls_result  = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      cls_result = QNAN;
    end else if (a_inf) begin
      cls_result = a_q;
    end else if (b_inf) begin
      cls_result = in_data;
    end else if (a_zero && b_zero) begin
      cls_result = {sa & sb, 31'b0};
    end else if (a_zero) begin
      cls_result = in_data;
    end else if (b_zero) begin
      cls_result = a_q;
    end else begin
      cls_special = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    exp1_d    = exp1_q;
    exp2_d    = exp2_q;
    frac1_d   = frac1_q;
    frac2_d   = frac2_q;
    special_d = special_q;
    sres_d    = sres_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b1;

    unique case (state_q)
      WAIT_A: begin
        if (in_valid) begin
          a_d     = in_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (in_valid) begin
          sign1_d   = sa;
          sign2_d   = sb;
          exp1_d    = ea;
          exp2_d    = eb;
          frac1_d   = a_zero ? '0 : fa;
          frac2_d   = b_zero ? '0 : fb;
          special_d = cls_special;
          sres_d    = cls_result;
          state_d   = FULL;
        end
      end
      FULL: begin
        in_ready = out_ready;
        if (out_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          // The transfer edge doubles as the capture edge for the next A.
          if (in_valid) begin
            a_d     = in_data;
            state_d = WAIT_B;
          end else begin
            state_d = WAIT_A;
          end
        end
      end
      default: state_d = WAIT_A;
    endcase

    // Flush overrides everything, including a transfer in the same cycle.
    if (flush) begin
      state_d = WAIT_A;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_A;
      a_q       <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      exp1_q    <= '0;
      exp2_q    <= '0;
      frac1_q   <= '0;
      frac2_q   <= '0;
      special_q <= 1'b0;
      sres_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      exp1_q    <= exp1_d;
      exp2_q    <= exp2_d;
      frac1_q   <= frac1_d;
      frac2_q   <= frac2_d;
      special_q <= special_d;
      sres_q    <= sres_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid      = (state_q == FULL);
  assign sign1          = sign1_q;
  assign sign2          = sign2_q;
  assign exp1           = exp1_q;
  assign exp2           = exp2_q;
  assign frac1          = frac1_q;
  assign frac2          = frac2_q;
  assign special        = special_q;
  assign special_result = sres_q;
  assign pair_cnt       = cnt_q;

endmodule

// File: tb/tb_fp_operand_stager.sv
// Testbench for fp_operand_stager: directed pairs with hand-computed
// expected fields pushed to a queue; a monitor pops on every transfer.
module tb_fp_operand_stager;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             sign1, sign2;
  logic [7:0]       exp1, exp2;
  logic [22:0]      frac1, frac2;
  logic             special;
  logic [31:0]      special_result;
  logic [CNT_W-1:0] pair_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_cnt = 0;

  typedef struct packed {
    logic        s1, s2;
    logic [7:0]  e1, e2;
    logic [22:0] f1, f2;
    logic        sp;
    logic [31:0] r;
  } exp_t;

  exp_t sb_q[$];

  fp_operand_stager #(.CNT_W(CNT_W), .QNAN(32'h7FC0_0000)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign1(sign1), .sign2(sign2), .exp1(exp1), .exp2(exp2),
    .frac1(frac1), .frac2(frac2), .special(special),
    .special_result(special_result), .pair_cnt(pair_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input logic s1, input logic [7:0] e1, input logic [22:0] f1,
                      input logic s2, input logic [7:0] e2, input logic [22:0] f2,
                      input logic sp, input logic [31:0] r);
    exp_t e;
    e = '{s1: s1, s2: s2, e1: e1, e2: e2, f1: f1, f2: f2, sp: sp, r: r};
    sb_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] w);
    logic acc;
    int unsigned n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every transfer pops and compares one expected pair.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pair", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sign1", 32'(sign1), 32'(e.s1));
        chk("sign2", 32'(sign2), 32'(e.s2));
        chk("exp1", 32'(exp1), 32'(e.e1));
        chk("exp2", 32'(exp2), 32'(e.e2));
        chk("frac1", 32'(frac1), 32'(e.f1));
        chk("frac2", 32'(frac2), 32'(e.f2));
        chk("special", 32'(special), 32'(e.sp));
        chk("special_result", special_result, e.r);
      end
    end
  end

  initial begin
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_exp1", 32'(exp1), 32'd0);
    chk("rst_frac2", 32'(frac2), 32'd0);
    chk("rst_special", 32'(special), 32'd0);
    chk("rst_special_result", special_result, 32'd0);
    chk("rst_pair_cnt", 32'(pair_cnt), 32'd0);
    #10;
    rst_n = 1'b1;
    tick();

    // Normal pair 1.0 + 2.0
    push(1'b0, 8'd127, 23'd0, 1'b0, 8'd128, 23'd0, 1'b0, 32'h0);
    send(32'h3F80_0000);
    send(32'h4000_0000);
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    tick();
    exp_cnt++;
    chk("pair_cnt_first", 32'(pair_cnt), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // Back-to-back special cases
    push(1'b0, 8'd255, 23'd0, 1'b1, 8'd255, 23'd0, 1'b1, 32'h7FC0_0000);
    send(32'h7F80_0000);
    send(32'hFF80_0000);
    push(1'b0, 8'd255, 23'h40_0001, 1'b0, 8'd127, 23'd0, 1'b1, 32'h7FC0_0000);
    send(32'h7FC0_0001);
    send(32'h3F80_0000);
    push(1'b0, 8'd0, 23'd0, 1'b1, 8'd128, 23'h40_0000, 1'b1, 32'hC040_0000);
    send(32'h0000_0001);
    send(32'hC040_0000);
    push(1'b1, 8'd0, 23'd0, 1'b1, 8'd0, 23'd0, 1'b1, 32'h8000_0000);
    send(32'h8000_0000);
    send(32'h8000_0000);
    tick();
    exp_cnt += 4;
    chk("pair_cnt_specials", 32'(pair_cnt), exp_cnt % 16);

    // Backpressure: 3.0 + 1.0 held while next word waits
    out_ready = 1'b0;
    push(1'b0, 8'd128, 23'h40_0000, 1'b0, 8'd127, 23'd0, 1'b0, 32'h0);
    send(32'h4040_0000);
    send(32'h3F80_0000);
    in_valid = 1'b1;
    in_data  = 32'hBF80_0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_exp1", 32'(exp1), 32'd128);
      chk("stall_frac1", 32'(frac1), 32'h40_0000);
      chk("stall_exp2", 32'(exp2), 32'd127);
    end
    tick();
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_cnt++;
    chk("after_stall_out_valid", 32'(out_valid), 32'd0);
    chk("after_stall_in_ready_waitb", 32'(in_ready), 32'd1);
    chk("after_stall_pair_cnt", 32'(pair_cnt), exp_cnt % 16);
    // -1.0 (captured during transfer) + Inf -> Inf from B
    push(1'b1, 8'd127, 23'd0, 1'b0, 8'd255, 23'd0, 1'b1, 32'h7F80_0000);
    send(32'h7F80_0000);
    tick();
    exp_cnt++;

    // Flush in WAIT_B discards partial A
    send(32'h1234_5678);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    push(1'b0, 8'd128, 23'd0, 1'b0, 8'd0, 23'd0, 1'b1, 32'h4000_0000);
    send(32'h4000_0000);
    send(32'h0000_0000);
    tick();
    exp_cnt++;
    chk("flush_waitb_pair_cnt", 32'(pair_cnt), exp_cnt % 16);

    // Flush while FULL drops the pair without counting
    out_ready = 1'b0;
    send(32'h3F80_0000);
    send(32'h3F80_0000);
    chk("full_before_flush", 32'(out_valid), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b1;
    chk("flush_full_out_valid", 32'(out_valid), 32'd0);
    chk("flush_full_pair_cnt", 32'(pair_cnt), exp_cnt % 16);

    // Async reset mid-FULL
    out_ready = 1'b0;
    send(32'h3F80_0000);
    send(32'h4000_0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_pair_cnt", 32'(pair_cnt), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    exp_cnt = 0;

    // 17 transfers wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++) begin
      push(1'b0, 8'd127, 23'd0, 1'b0, 8'd128, 23'd0, 1'b0, 32'h0);
      send(32'h3F80_0000);
      send(32'h4000_0000);
    end
    tick();
    exp_cnt += 17;
    chk("pair_cnt_wrap", 32'(pair_cnt), 32'd1);
    chk("pair_cnt_wrap_model", 32'(pair_cnt), exp_cnt % 16);

    repeat (3) tick();
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
